// File: rtl/axis_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axis_pkt_arbiter
// Brief    : Packet-granular round-robin arbiter that shares one AXI-Stream
//            sink (FIFO write side) between NUM_SRC requesters. A grant is
//            held from the first beat through the beat carrying last, so
//            packets never interleave. Enforces MAX_BEATS with a forced last
//            and a sticky truncation flag, and counts completed packets.
// Revision : 1.0 - initial release
// ============================================================================
module axis_pkt_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 2048
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_data,
  input  logic [NUM_SRC-1:0]            s_axis_valid,
  input  logic [NUM_SRC-1:0]            s_axis_last,
  output logic [NUM_SRC-1:0]            s_axis_ready,
  output logic [DATA_WIDTH-1:0]         m_axis_data,
  output logic                          m_axis_valid,
  output logic                          m_axis_last,
  input  logic                          m_axis_ready,
  output logic [$clog2(NUM_SRC)-1:0]    grant,
  output logic                          busy,
  output logic                          err_trunc,
  output logic [15:0]                   pkt_count
);

  localparam int GRANT_W = $clog2(NUM_SRC);
  localparam int CNT_W   = 12;

  // Counter value of the final legal beat of a packet.
  localparam logic [CNT_W-1:0]   C_LAST_BEAT  = CNT_W'(MAX_BEATS - 1);
  // Reset value of last_grant so that source 0 wins the first arbitration.
  localparam logic [GRANT_W-1:0] C_LAST_GRANT = GRANT_W'(NUM_SRC - 1);
  localparam logic [GRANT_W:0]   C_NUM_SRC    = (GRANT_W + 1)'(NUM_SRC);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t               r_state;
  logic [GRANT_W-1:0]   r_last_grant;
  logic [CNT_W-1:0]     r_beat_cnt;

  logic [DATA_WIDTH-1:0] w_src_data [NUM_SRC];
  logic                  w_in_xfer;
  logic                  w_force_last;
  logic                  w_beat;
  logic                  w_pkt_done;
  logic [GRANT_W-1:0]    w_arb_sel;
  logic                  w_arb_hit;
  logic [GRANT_W:0]      w_cand;
  logic [GRANT_W-1:0]    w_cand_idx;

  // Split the flat data bus into one word per source.
  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
      assign w_src_data[i] = s_axis_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign w_in_xfer    = (r_state == ST_XFER);
  assign w_force_last = (r_beat_cnt == C_LAST_BEAT);

  // Combinational pass-through of the granted source while in XFER.
  assign m_axis_valid = w_in_xfer & s_axis_valid[grant];
  assign m_axis_data  = w_in_xfer ? w_src_data[grant] : '0;
  assign m_axis_last  = w_in_xfer & (s_axis_last[grant] | w_force_last);

  assign w_beat     = m_axis_valid & m_axis_ready;
  assign w_pkt_done = w_beat & m_axis_last;

  // Only the granted source sees the sink's ready; all others are held off.
  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_ready
      assign s_axis_ready[i] = w_in_xfer && (grant == GRANT_W'(i)) && m_axis_ready;
    end
  endgenerate

  // Round-robin search: offsets are walked from farthest to nearest so that
  // the nearest requester after last_grant is the one left standing; the
  // last granted source itself sits at the farthest offset (lowest priority).
  always_comb begin
    w_arb_sel  = r_last_grant;
    w_arb_hit  = 1'b0;
    w_cand     = '0;
    w_cand_idx = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      w_cand = {1'b0, r_last_grant} + (GRANT_W + 1)'(k);
      if (w_cand >= C_NUM_SRC) begin
        w_cand = w_cand - C_NUM_SRC;
      end
      w_cand_idx = w_cand[GRANT_W-1:0];
      if (s_axis_valid[w_cand_idx]) begin
        w_arb_sel = w_cand_idx;
        w_arb_hit = 1'b1;
      end
    end
  end

  // Arbitration FSM with beat counting, truncation flag and packet statistics.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_state      <= ST_IDLE;
      grant        <= '0;
      r_last_grant <= C_LAST_GRANT;
      r_beat_cnt   <= '0;
      busy         <= 1'b0;
      err_trunc    <= 1'b0;
      pkt_count    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_arb_hit) begin
            grant      <= w_arb_sel;
            r_beat_cnt <= '0;
            r_state    <= ST_XFER;
            busy       <= 1'b1;
          end
        end
        ST_XFER: begin
          if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            // A forced last on a beat the source did not mark is a truncation.
            if (w_force_last && !s_axis_last[grant]) begin
              err_trunc <= 1'b1;
            end
          end
          if (w_pkt_done) begin
            pkt_count    <= pkt_count + 16'd1;
            r_last_grant <= grant;
            r_state      <= ST_IDLE;
            busy         <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_pkt_arbiter
// Brief    : Self-checking bench for axis_pkt_arbiter (4 sources, 32-bit data,
//            MAX_BEATS = 8). Per-source packet queues drive the inputs, and a
//            scoreboard of expected FIFO beats is compared as beats emerge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_pkt_arbiter;

  localparam int NS   = 4;
  localparam int DW   = 32;
  localparam int MAXB = 8;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            gap;
  } beat_t;

  typedef struct {
    int            src;
    logic [DW-1:0] data;
    logic          last;
    int            cyc;
  } exp_t;

  typedef struct {
    int            src;
    int            len;
    bit            bp;
    logic [DW-1:0] base;
    int            exp_grant;
    int            exp_pkt;
  } vec_t;

  logic              clk;
  logic              reset_n;
  logic [NS*DW-1:0]  s_data;
  logic [NS-1:0]     s_valid;
  logic [NS-1:0]     s_last;
  logic [NS-1:0]     s_ready;
  logic [DW-1:0]     m_data;
  logic              m_valid;
  logic              m_last;
  logic              m_ready;
  logic [1:0]        grant;
  logic              busy;
  logic              err_trunc;
  logic [15:0]       pkt_count;

  beat_t         src_q [NS][$];
  exp_t          sb [$];
  logic [NS-1:0] xfer_flag;
  logic [NS-1:0] loaded;
  int            gap_left [NS];
  bit            bp_mode;
  int            cyc;
  int            checks;
  int            errors;

  axis_pkt_arbiter #(
    .NUM_SRC    (NS),
    .DATA_WIDTH (DW),
    .MAX_BEATS  (MAXB)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_axis_data  (s_data),
    .s_axis_valid (s_valid),
    .s_axis_last  (s_last),
    .s_axis_ready (s_ready),
    .m_axis_data  (m_data),
    .m_axis_valid (m_valid),
    .m_axis_last  (m_last),
    .m_axis_ready (m_ready),
    .grant        (grant),
    .busy         (busy),
    .err_trunc    (err_trunc),
    .pkt_count    (pkt_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Source driver: presents queue heads, honours per-beat gaps, pops on handshake.
  initial begin
    s_valid = '0;
    s_last  = '0;
    s_data  = '0;
    m_ready = 1'b1;
    loaded  = '0;
    for (int s = 0; s < NS; s++) gap_left[s] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int s = 0; s < NS; s++) begin
        if (xfer_flag[s] && src_q[s].size() > 0) begin
          void'(src_q[s].pop_front());
          loaded[s] = 1'b0;
        end
        if (!loaded[s] && src_q[s].size() > 0) begin
          gap_left[s] = src_q[s][0].gap;
          loaded[s]   = 1'b1;
        end
        if (loaded[s] && gap_left[s] == 0) begin
          s_valid[s]         = 1'b1;
          s_last[s]          = src_q[s][0].last;
          s_data[s*DW +: DW] = src_q[s][0].data;
        end else begin
          s_valid[s] = 1'b0;
          s_last[s]  = 1'b0;
          if (loaded[s]) gap_left[s]--;
        end
      end
      m_ready = bp_mode ? ~m_ready : 1'b1;
    end
  end

  // Sink monitor: checks ready isolation every cycle and each transferred beat.
  initial begin
    exp_t          e;
    logic [NS-1:0] allowed;
    xfer_flag = '0;
    forever begin
      @(negedge clk);
      xfer_flag = '0;
      if (!reset_n) begin
        xfer_flag = s_ready & s_valid;
        if (sb.size() > 0) begin
          allowed = m_ready ? (NS'(1) << sb[0].src) : '0;
          chk("ready_isolation", 64'(s_ready & ~allowed), 64'd0);
        end
        if (m_valid && m_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", m_data);
          end else begin
            e = sb.pop_front();
            chk("beat_data", 64'(m_data), 64'(e.data));
            chk("beat_last", 64'(m_last), 64'(e.last));
            chk("beat_grant", 64'(grant), 64'(e.src));
            chk("beat_src_ready", 64'(s_ready), 64'(NS'(1) << e.src));
            if (e.cyc >= 0) chk("beat_cycle", 64'(cyc), 64'(e.cyc));
          end
        end
      end
    end
  end

  // Queue a packet on a source and push its expected sink beats.
  task automatic send_pkt(input int src, input int n, input logic [DW-1:0] base,
                          input int first_cyc, input int gap_idx, input int gap_len);
    beat_t b;
    exp_t  e;
    for (int i = 0; i < n; i++) begin
      b.data = base + DW'(i);
      b.last = (i == n - 1);
      b.gap  = (i == gap_idx) ? gap_len : 0;
      src_q[src].push_back(b);
      e.src  = src;
      e.data = b.data;
      e.last = (i == n - 1) || (i == MAXB - 1);
      e.cyc  = (first_cyc >= 0) ? first_cyc + i : -1;
      sb.push_back(e);
    end
  endtask

  task automatic wait_sb(input int target, input int limit);
    int n;
    n = 0;
    while (sb.size() > target && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() > target) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d beats pending, expected %0d", sb.size(), target);
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b1;
    bp_mode = 1'b0;
    for (int s = 0; s < NS; s++) src_q[s].delete();
    loaded = '0;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_pkt_count", 64'(pkt_count), 64'd0);
    chk("rst_err_trunc", 64'(err_trunc), 64'd0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
  endtask

  vec_t vecs [4];

  initial begin
    int c0;
    checks  = 0;
    errors  = 0;
    bp_mode = 1'b0;
    reset_n = 1'b1;

    vecs[0] = '{src: 2, len: 3, bp: 1'b0, base: 32'hA0,  exp_grant: 2, exp_pkt: 1};
    vecs[1] = '{src: 0, len: 1, bp: 1'b0, base: 32'h100, exp_grant: 0, exp_pkt: 2};
    vecs[2] = '{src: 3, len: 4, bp: 1'b1, base: 32'h200, exp_grant: 3, exp_pkt: 3};
    vecs[3] = '{src: 1, len: 2, bp: 1'b0, base: 32'h300, exp_grant: 1, exp_pkt: 4};

    apply_reset();

    // Lone-requester packets, one with alternating sink backpressure.
    for (int v = 0; v < 4; v++) begin
      @(posedge clk);
      #2;
      bp_mode = vecs[v].bp;
      send_pkt(vecs[v].src, vecs[v].len, vecs[v].base,
               vecs[v].bp ? -1 : cyc + 2, -1, 0);
      wait_sb(0, 100);
      bp_mode = 1'b0;
      @(negedge clk);
      chk("vec_grant", 64'(grant), 64'(vecs[v].exp_grant));
      chk("vec_pkt_count", 64'(pkt_count), 64'(vecs[v].exp_pkt));
      chk("vec_idle_busy", 64'(busy), 64'd0);
    end

    // All sources request at once: order 0,1,2,3,0 with one idle cycle between.
    apply_reset();
    c0 = cyc + 2;
    for (int s = 0; s < NS; s++) send_pkt(s, 2, 32'h1000 + DW'(s * 16), c0 + 3 * s, -1, 0);
    send_pkt(0, 2, 32'h1080, c0 + 12, -1, 0);
    wait_sb(0, 100);
    @(negedge clk);
    chk("rr_pkt_count", 64'(pkt_count), 64'd5);
    chk("rr_grant", 64'(grant), 64'd0);

    // Granted source stalls mid-packet while another source requests.
    @(posedge clk);
    #2;
    send_pkt(1, 3, 32'h2000, -1, 1, 5);
    send_pkt(3, 1, 32'h2100, -1, -1, 0);
    wait_sb(3, 50);
    repeat (3) begin
      @(negedge clk);
      chk("stall_grant", 64'(grant), 64'd1);
      chk("stall_busy", 64'(busy), 64'd1);
      chk("stall_m_valid", 64'(m_valid), 64'd0);
    end
    wait_sb(0, 100);
    @(negedge clk);
    chk("stall_pkt_count", 64'(pkt_count), 64'd7);
    chk("stall_grant_end", 64'(grant), 64'd3);

    // Ten-beat packet truncated at MAX_BEATS; the tail re-arbitrates.
    @(posedge clk);
    #2;
    chk("trunc_err_before", 64'(err_trunc), 64'd0);
    send_pkt(1, 10, 32'h3000, -1, -1, 0);
    wait_sb(2, 100);
    @(negedge clk);
    chk("trunc_err_rise", 64'(err_trunc), 64'd1);
    chk("trunc_gap_busy", 64'(busy), 64'd0);
    chk("trunc_gap_valid", 64'(m_valid), 64'd0);
    wait_sb(0, 100);
    @(negedge clk);
    chk("trunc_pkt_count", 64'(pkt_count), 64'd9);
    chk("trunc_err_sticky", 64'(err_trunc), 64'd1);

    // Reset after beat 2 of 5, then sources 0 and 2 contend: 0 must win.
    @(posedge clk);
    #2;
    send_pkt(2, 5, 32'h4000, -1, -1, 0);
    wait_sb(3, 100);
    @(posedge clk);
    #2;
    apply_reset();
    c0 = cyc + 2;
    send_pkt(0, 1, 32'h5000, c0, -1, 0);
    send_pkt(2, 1, 32'h5100, c0 + 2, -1, 0);
    wait_sb(0, 100);
    @(negedge clk);
    chk("post_rst_pkt_count", 64'(pkt_count), 64'd2);
    chk("post_rst_grant", 64'(grant), 64'd2);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_pkt_arbiter.md
# axis_pkt_arbiter

Packet-granular round-robin arbiter that shares one AXI-Stream sink, the write side of the stream FIFO, between `NUM_SRC` AXI-Stream requesters. A grant is held from the first beat of a packet through the beat carrying `last`, so packets from different sources never interleave inside the FIFO. The block also enforces a maximum packet length and reports the active grant and per-run packet statistics.

## Interface
Parameters:
- `NUM_SRC`, 4: number of requesting sources (2..8).
- `DATA_WIDTH`, 32: stream data width.
- `MAX_BEATS`, 2048: longest legal packet in beats; matches FIFO depth.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  synchronous, active-high reset (name kept per codebase; asserted = 1).
- `s_axis_data`  in  `NUM_SRC*DATA_WIDTH`  source data, source i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `s_axis_valid`  in  `NUM_SRC`  per-source valid.
- `s_axis_last`  in  `NUM_SRC`  per-source end-of-packet.
- `s_axis_ready`  out  `NUM_SRC`  per-source ready.
- `m_axis_data`  out  `DATA_WIDTH`  data to FIFO.
- `m_axis_valid`  out  1  valid to FIFO.
- `m_axis_last`  out  1  last to FIFO; forced on truncation.
- `m_axis_ready`  in  1  FIFO ready (not full).
- `grant`  out  `$clog2(NUM_SRC)`  index of the source currently or last granted.
- `busy`  out  1  high while in XFER.
- `err_trunc`  out  1  sticky; a packet hit `MAX_BEATS` without `last`.
- `pkt_count`  out  16  packets completed since reset; wraps at 0xFFFF→0.

## Operation
- State machine: IDLE, XFER.
  - IDLE:
    - `m_axis_valid` = 0 and all `s_axis_ready` = 0.
    - If any `s_axis_valid` is set, select the first requester scanning from `(last_grant+1) mod NUM_SRC` upward with wrap.
    - Register the selection into `grant` and go to XFER.
  - XFER: combinational pass-through of the granted source.
    - `m_axis_data`, `m_axis_valid` and `m_axis_last` come from `s_axis_*[grant]`.
    - `s_axis_ready[grant]` = `m_axis_ready`; all other readies are 0.
    - A beat transfers when `m_axis_valid && m_axis_ready`.
- Beat counter (12 bits), cleared on entry to XFER and incremented per transferred beat.
  - The beat at count `MAX_BEATS-1` is the final beat of the packet. `m_axis_last` is forced to 1 on it, and `err_trunc` sets if the source's `last` was 0.
  - Any remaining source beats arrive as a new packet after re-arbitration.
- A transfer with `m_axis_last` = 1 does four things:
  - increments `pkt_count`;
  - stores `last_grant` = `grant`;
  - returns the FSM to IDLE;
  - `grant` keeps its value.
- Requests are level-sensitive. A source that drops valid mid-packet keeps the grant; the arbiter waits indefinitely.
- `err_trunc` clears only on reset.

## Timing
- Reset values:
  - state = IDLE, `grant` = 0, `last_grant` = `NUM_SRC-1` (so source 0 wins first), beat counter = 0.
  - `busy` = 0, `err_trunc` = 0, `pkt_count` = 0.
  - `m_axis_valid` = 0, `m_axis_last` = 0, `m_axis_data` = 0, all `s_axis_ready` = 0.
- Reset mid-packet aborts the transfer immediately. The FIFO may hold a partial packet, and the block makes no attempt to repair it.
- Arbitration latency is 1 cycle. A valid first seen in IDLE at cycle N gives a grant at N+1, and the first beat can transfer at N+1.
- Inside a packet there are 0 bubbles: one beat per cycle while valid and ready.
- Packet-to-packet gap is 1 idle cycle (the IDLE arbitration cycle), including back-to-back packets from the same source.
- Simultaneous requests resolve round-robin as described. A lone requester wins every arbitration.
- When `m_axis_ready` = 0, the granted source sees ready = 0 in the same cycle and no beat is lost or duplicated.
- `busy` is a registered state decode: 1 in XFER.

## Test plan
- Single source, `NUM_SRC`=4: source 2 sends 3 beats 0xA0, 0xA1, 0xA2 with last on 0xA2. FIFO sees the same three beats in order starting 1 cycle after valid; `pkt_count` = 1; `grant` = 2.
- All four sources hold 2-beat packets continuously after reset. Grant order is 0, 1, 2, 3, 0; each packet's beats are contiguous; there is exactly 1 idle cycle between packets.
- Backpressure: `m_axis_ready` toggles 1, 0, 1, 0 during a 4-beat packet. Exactly 4 transfers occur with no duplicates, and non-granted `s_axis_ready` stays 0 throughout.
- Truncation with `MAX_BEATS`=8: source 1 sends 10 beats with last on beat 10.
  - Beat 8 appears with `m_axis_last` = 1 and `err_trunc` rises.
  - Beats 9–10 are re-arbitrated as a 2-beat packet.
  - `pkt_count` = 2.
- Reset mid-packet: assert `reset_n` = 1 after beat 2 of 5. The next cycle shows `busy` = 0, `m_axis_valid` = 0 and `pkt_count` = 0, and the next arbitration grants source 0 first.
- Stalled source: the granted source drops valid for 5 cycles mid-packet while another source requests. The grant does not change, and the packet completes when valid returns.
